// File: rtl/rf_pkg.sv
// Shared defaults and typedefs for the multi-port register file and its read ports.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage : rf_pkg

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage mux, write bypass, zero-register override and busy lookup.
module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         active,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0] store,
    input  logic [(2**ADDR_W)-1:0]       pend,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]     wr_data,
    input  logic                         mark_en,
    input  logic [ADDR_W-1:0]            mark_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] store_arr;
    logic                         wr_hit;
    logic                         mark_hit;

    assign store_arr = store;
    assign mark_hit  = mark_en && (mark_addr == rd_addr);

    // Ascending scan so the highest-indexed matching write port is the one forwarded.
    always_comb begin
        rd_data = store_arr[rd_addr];
        rd_busy = pend[rd_addr];
        wr_hit  = 1'b0;
        if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
                    wr_hit  = 1'b1;
                    rd_data = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if (wr_hit) begin
                rd_busy = mark_hit;
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
        if (!active) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// Parameterised multi-port register file with per-register pending (busy) scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    output logic                     busy_any
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0][DATA_W-1:0] mem_next;
    logic [DEPTH-1:0]             pend;
    logic [DEPTH-1:0]             pend_next;
    logic [DEPTH*DATA_W-1:0]      store_flat;

    // Later ports overwrite earlier ones, so the highest index wins on an address collision.
    always_comb begin
        mem_next  = mem;
        pend_next = pend;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                pend_next[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
                if (!((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
                    mem_next[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
        // A mark after the clears: a newly issued producer supersedes the one writing back.
        if (mark_en) begin
            pend_next[mark_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            pend <= '0;
        end else begin
            mem  <= mem_next;
            pend <= pend_next;
        end
    end

    assign store_flat = mem;
    assign busy_any   = |pend;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .active    (rst_n),
            .rd_addr   (rd_addr[i*ADDR_W +: ADDR_W]),
            .store     (store_flat),
            .pend      (pend),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .mark_en   (mark_en),
            .mark_addr (mark_addr),
            .rd_data   (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy   (rd_busy[i])
        );
    end

endmodule : regfile_mp
